id_ex_pipe_reg: RTL

Parametrised ID→EXE pipeline register with a valid/ready handshake, flush, bubble insertion and an optional one-entry skid buffer. It sits between the instruction-decode stage and the execute stage. It carries operands, destination, PC, branch type, ALU command and memory/write-back enables. Unlike a plain clocked latch, it lets EXE back-pressure ID without dropping or duplicating an instruction. It also guarantees that no enable leaks out on a bubble or a flush.

---
 rtl/id_ex_pkg.sv | 42 ++++
 rtl/id_ex_skid.sv | 51 +++++
 rtl/id_ex_pipe_reg.sv | 138 +++++++++++++
 3 files changed

// File: rtl/id_ex_pkg.sv
// Shared types and constants for the ID->EXE pipeline register.
// Payload widths here must match the id_ex_pipe_reg parameter defaults.
package id_ex_pkg;

  localparam int ID_EX_DATA_W = 32;
  localparam int ID_EX_REG_AW = 5;
  localparam int ID_EX_CMD_W  = 4;
  localparam int ID_EX_BR_W   = 2;

  typedef enum logic [ID_EX_BR_W-1:0] {
    BR_NONE = 2'd0,
    BR_BEQ  = 2'd1,
    BR_BNE  = 2'd2,
    BR_JMP  = 2'd3
  } br_type_e;

  // Fields that must never be seen active while the output is invalid.
  typedef struct packed {
    br_type_e br_type;
    logic     mem_r_en;
    logic     mem_w_en;
    logic     wb_en;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_CLEAR = '{
    br_type:  BR_NONE,
    mem_r_en: 1'b0,
    mem_w_en: 1'b0,
    wb_en:    1'b0
  };

  typedef struct packed {
    logic [ID_EX_REG_AW-1:0] dest;
    logic [ID_EX_DATA_W-1:0] val1;
    logic [ID_EX_DATA_W-1:0] val2;
    logic [ID_EX_DATA_W-1:0] reg2;
    logic [ID_EX_DATA_W-1:0] pc;
    logic [ID_EX_CMD_W-1:0]  exe_cmd;
    id_ex_ctrl_t             ctrl;
  } id_ex_payload_t;

endpackage

// File: rtl/id_ex_skid.sv
// One-entry skid buffer for the ID->EXE register: absorbs the instruction
// accepted while the main register is stalled, so in_ready can be a flop.
module id_ex_skid
  import id_ex_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           i_flush,
  input  logic           i_load,
  input  logic           i_pop,
  input  id_ex_payload_t i_payload,
  output logic           o_valid,
  output logic           o_ready,
  output id_ex_payload_t o_payload
);

  logic           r_valid;
  logic           r_ready;
  id_ex_payload_t r_payload;

  // r_ready is kept as the exact complement of r_valid so that the upstream
  // ready comes straight from a flop, with no path from out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ready <= 1'b0;
    end else if (i_pop) begin
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end
  end

  // NOTE: the payload storage has no reset; it is only ever read while
  // r_valid is set, and leaving it unreset keeps it out of the reset tree.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_payload <= i_payload;
    end
  end

  assign o_valid   = r_valid;
  assign o_ready   = r_ready;
  assign o_payload = r_payload;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EXE pipeline register with valid/ready handshake, flush and bubbles.
// Define ID_EX_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module id_ex_pipe_reg
  import id_ex_pkg::*;
#(
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int REG_AW = ID_EX_REG_AW,
  parameter int CMD_W  = ID_EX_CMD_W,
  parameter int BR_W   = ID_EX_BR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] dest_in,
  input  logic [DATA_W-1:0] val1_in,
  input  logic [DATA_W-1:0] val2_in,
  input  logic [DATA_W-1:0] reg2_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [BR_W-1:0]   br_type_in,
  input  logic [CMD_W-1:0]  exe_cmd_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              wb_en_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] dest,
  output logic [DATA_W-1:0] val1,
  output logic [DATA_W-1:0] val2,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] pc_out,
  output logic [BR_W-1:0]   br_type,
  output logic [CMD_W-1:0]  exe_cmd,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              wb_en
);

  id_ex_payload_t w_in_payload;
  id_ex_payload_t w_main_src;
  id_ex_payload_t r_main;
  logic           r_out_valid;
  logic           w_main_free;
  logic           w_in_xfer;
  logic           w_main_load;

  always_comb begin
    w_in_payload                  = '0;
    w_in_payload.dest             = dest_in;
    w_in_payload.val1             = val1_in;
    w_in_payload.val2             = val2_in;
    w_in_payload.reg2             = reg2_in;
    w_in_payload.pc               = pc_in;
    w_in_payload.exe_cmd          = exe_cmd_in;
    w_in_payload.ctrl.br_type     = br_type_e'(br_type_in);
    w_in_payload.ctrl.mem_r_en    = mem_r_en_in;
    w_in_payload.ctrl.mem_w_en    = mem_w_en_in;
    w_in_payload.ctrl.wb_en       = wb_en_in;
  end

  // The main register can take a new entry when empty or being consumed.
  assign w_main_free = !r_out_valid || out_ready;
  assign w_in_xfer   = in_valid && in_ready;

`ifdef ID_EX_SKID_EN
  logic           w_skid_valid;
  logic           w_skid_load;
  logic           w_skid_pop;
  id_ex_payload_t w_skid_payload;

  // The skid only fills while main is held; it drains first when main frees,
  // so the older instruction always reaches EXE ahead of any newer one.
  assign w_skid_load = w_in_xfer && !w_main_free;
  assign w_skid_pop  = w_main_free && w_skid_valid;

  id_ex_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (flush),
    .i_load    (w_skid_load),
    .i_pop     (w_skid_pop),
    .i_payload (w_in_payload),
    .o_valid   (w_skid_valid),
    .o_ready   (in_ready),
    .o_payload (w_skid_payload)
  );

  assign w_main_load = w_main_free && (w_skid_valid || w_in_xfer);

  always_comb begin
    w_main_src = w_in_payload;
    if (w_skid_valid) begin
      w_main_src = w_skid_payload;
    end
  end
`else
  // NOTE: in_ready depends combinationally on out_ready here; EXE must not
  // derive out_ready from in_ready or a combinational loop is formed.
  assign in_ready    = w_main_free;
  assign w_main_load = w_in_xfer;

  always_comb begin
    w_main_src = w_in_payload;
  end
`endif

  // Flush wins over everything; bubbles and flushes zero only the control
  // fields, data fields keep their stale contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_main      <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_main.ctrl <= CTRL_CLEAR;
    end else if (w_main_load) begin
      r_out_valid <= 1'b1;
      r_main      <= w_main_src;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_main.ctrl <= CTRL_CLEAR;
    end
  end

  assign out_valid = r_out_valid;
  assign dest      = r_main.dest;
  assign val1      = r_main.val1;
  assign val2      = r_main.val2;
  assign reg2      = r_main.reg2;
  assign pc_out    = r_main.pc;
  assign exe_cmd   = r_main.exe_cmd;
  assign br_type   = r_main.ctrl.br_type;
  assign mem_r_en  = r_main.ctrl.mem_r_en;
  assign mem_w_en  = r_main.ctrl.mem_w_en;
  assign wb_en     = r_main.ctrl.wb_en;

endmodule
